// File: rtl/aes_gcm_input_sequencer.sv
// Buffers one AES-GCM instance (header + AAD/PT blocks) and replays it gap-free to the first stage.
// Ports: clk/rst_n, hdr valid/ready + key/iv/size, blk valid/ready + data, stage outputs, o_busy, o_err. Optional: AES_SEQ_ABORT_EN adds i_abort.
module aes_gcm_input_sequencer #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_hdr_valid,
  output logic         o_hdr_ready,
  input  logic [0:127] i_hdr_key,
  input  logic [0:95]  i_hdr_iv,
  input  logic [0:127] i_hdr_size,
  input  logic         i_blk_valid,
  output logic         o_blk_ready,
  input  logic [0:127] i_blk_data,
`ifdef AES_SEQ_ABORT_EN
  input  logic         i_abort,
`endif
  output logic [0:127] o_cipher_key,
  output logic [0:95]  o_iv,
  output logic [0:127] o_instance_size,
  output logic [0:127] o_aad,
  output logic [0:127] o_plain_text,
  output logic         o_new_instance,
  output logic         o_pt_instance,
  output logic         o_busy,
  output logic         o_err
);

  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, LOAD, ISSUE} state_t;

  state_t state, state_nx;

  logic [0:127] mem [DEPTH];
  logic [0:127] key_q;
  logic [0:127] size_q;
  logic [0:95]  iv_q;
  logic [CW-1:0] aad_q;
  logic [CW-1:0] total_q;
  logic [CW-1:0] wr_cnt;
  logic [CW-1:0] rd;

  logic [63:0] pt_len;
  logic [63:0] aad_len;
  logic [57:0] hdr_total;
  logic        hdr_bad;
  logic        hdr_fire;
  logic        blk_fire;
  logic        abort;
  logic        wr_last;
  logic        rd_last;

  assign pt_len    = i_hdr_size[0:63];
  assign aad_len   = i_hdr_size[64:127];
  // 58 bits holds the sum of two 57-bit block counts without wrap
  assign hdr_total = {1'b0, pt_len[63:7]}
                   + {1'b0, aad_len[63:7]};
  assign hdr_bad   = (hdr_total == 58'd0)
                   || (hdr_total > 58'(DEPTH))
                   || (|pt_len[6:0])
                   || (|aad_len[6:0]);

  // gated by rst_n so every output reads 0 while reset is held
  assign o_hdr_ready = rst_n && (state == IDLE);
  assign o_blk_ready = (state == LOAD) && (wr_cnt < total_q);
  assign o_busy      = (state != IDLE);

  assign hdr_fire = i_hdr_valid && o_hdr_ready;
  assign blk_fire = i_blk_valid && o_blk_ready;
  assign wr_last  = (wr_cnt == total_q - CW'(1));
  assign rd_last  = (rd == total_q - CW'(1));

`ifdef AES_SEQ_ABORT_EN
  assign abort = i_abort && (state == LOAD);
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (hdr_fire && !hdr_bad) state_nx = LOAD;
      end
      LOAD: begin
        if (abort)                   state_nx = IDLE;
        else if (blk_fire && wr_last) state_nx = ISSUE;
      end
      ISSUE: begin
        if (rd_last) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // block storage needs no reset: wr_cnt/rd gate what is read
  always_ff @(posedge clk) begin
    if (blk_fire && !abort) mem[wr_cnt[AW-1:0]] <= i_blk_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q           <= '0;
      iv_q            <= '0;
      size_q          <= '0;
      aad_q           <= '0;
      total_q         <= '0;
      wr_cnt          <= '0;
      rd              <= '0;
      o_cipher_key    <= '0;
      o_iv            <= '0;
      o_instance_size <= '0;
      o_aad           <= '0;
      o_plain_text    <= '0;
      o_new_instance  <= 1'b0;
      o_pt_instance   <= 1'b0;
      o_err           <= 1'b0;
    end else begin
      o_err <= 1'b0;
      if (state != ISSUE) begin
        o_aad          <= '0;
        o_plain_text   <= '0;
        o_new_instance <= 1'b0;
        o_pt_instance  <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          if (hdr_fire) begin
            if (hdr_bad) begin
              o_err <= 1'b1;
            end else begin
              key_q   <= i_hdr_key;
              iv_q    <= i_hdr_iv;
              size_q  <= i_hdr_size;
              aad_q   <= aad_len[7 +: CW];
              total_q <= hdr_total[CW-1:0];
              wr_cnt  <= '0;
            end
          end
        end
        LOAD: begin
          if (abort) begin
            wr_cnt <= '0;
            o_err  <= 1'b1;
          end else if (blk_fire) begin
            wr_cnt <= wr_cnt + CW'(1);
            if (wr_last) rd <= '0;
          end
        end
        ISSUE: begin
          rd             <= rd + CW'(1);
          o_new_instance <= (rd == '0);
          if (rd == '0) begin
            o_cipher_key    <= key_q;
            o_iv            <= iv_q;
            o_instance_size <= size_q;
          end
          if (rd < aad_q) begin
            o_aad         <= mem[rd[AW-1:0]];
            o_plain_text  <= '0;
            o_pt_instance <= 1'b0;
          end else begin
            o_aad         <= '0;
            o_plain_text  <= mem[rd[AW-1:0]];
            o_pt_instance <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/aes_gcm_input_sequencer.md
Name: aes_gcm_input_sequencer

Overview:
Upstream feeder for the first AES-GCM pipeline stage. It accepts one instance header (key, IV, lengths) and then that instance's 128-bit AAD and plaintext blocks over valid/ready handshakes, buffering them internally. It then replays the whole instance to the stage one block per consecutive cycle, with no gaps: AAD blocks first, then plaintext blocks, with a new-instance pulse on the first block. The downstream stage has no backpressure and its block counter free-runs, so the sequencer only starts issuing once the entire instance is buffered.

Parameters:
DEPTH, 16, maximum blocks (AAD+PT) per instance and buffer depth; power of two, >=2
AW, $clog2(DEPTH), buffer index width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
i_hdr_valid  in  1  header valid
o_hdr_ready  out  1  header ready
i_hdr_key  in  [0:127]  cipher key
i_hdr_iv  in  [0:95]  IV
i_hdr_size  in  [0:127]  [0:63]=PT length bits, [64:127]=AAD length bits
i_blk_valid  in  1  data block valid
o_blk_ready  out  1  data block ready
i_blk_data  in  [0:127]  AAD or PT block, in instance order
o_cipher_key  out  [0:127]  to stage key input
o_iv  out  [0:95]  to stage IV
o_instance_size  out  [0:127]  to stage size
o_aad  out  [0:127]  AAD block, zero when not AAD
o_plain_text  out  [0:127]  PT block, zero when not PT
o_new_instance  out  1  high with first block of instance
o_pt_instance  out  1  high while o_plain_text carries a PT block
o_busy  out  1  state != IDLE
o_err  out  1  one-cycle pulse on rejected header

Behaviour:
- Reset (async, rst_n=0): state=IDLE, all outputs 0, buffer count and indices 0. Reset mid-LOAD or mid-ISSUE discards the instance. The first edge after release behaves as IDLE.
- Derived at header accept: pt_blk=size[0:63]>>7, aad_blk=size[64:127]>>7, total=pt_blk+aad_blk, computed at 65 bits with no wrap.
- Header reject: pulse o_err 1 cycle, drop the header, stay IDLE. Reject if total==0, total>DEPTH, or either length field[57:63]/[121:127] is non-zero (not a multiple of 128).
- IDLE: o_hdr_ready=1, o_blk_ready=0. On hdr handshake (valid&ready), latch key/iv/size/aad_blk/total into shadow registers and go to LOAD. Outputs are not changed.
- LOAD: o_hdr_ready=0. o_blk_ready=1 while wr_cnt<total. Each handshake writes buf[wr_cnt] and increments wr_cnt. At the edge accepting block total-1 (edge T), go to ISSUE with rd=0.
- ISSUE: o_blk_ready=0, o_hdr_ready=0. Each edge loads the output registers from buf[rd] and increments rd. Block k is on the outputs from edge T+1+k to T+2+k.
  - k==0: o_new_instance=1. o_cipher_key, o_iv, o_instance_size load from shadow only at this edge and then hold until the next instance's block 0.
  - k<aad_blk: o_aad=buf[k], o_plain_text=0, o_pt_instance=0.
  - k>=aad_blk: o_plain_text=buf[k], o_aad=0, o_pt_instance=1.
  - At the edge loading block total-1, state returns to IDLE. A new header may be accepted while that block is still on the outputs.
- Edge after the final block: o_aad, o_plain_text, o_new_instance and o_pt_instance go to 0. Key, IV and size hold.
- Minimum gap: block 0 of instance N+1 comes no earlier than 2 cycles after block 0 of N. No back-to-back instances in 1 cycle.
- Outputs are registered. The stage sees block k with counter k when fed from these outputs.

Optional Feature:
Macro AES_SEQ_ABORT_EN.
- Defined: adds input i_abort (1 bit).
  - i_abort=1 in LOAD: discard buffered blocks, reset wr_cnt, pulse o_err, go to IDLE next edge.
  - i_abort in IDLE or ISSUE: ignored. ISSUE always completes.
  - i_abort coincident with a block handshake: abort wins, block discarded.
- Not defined: no port; LOAD exits only via completion or reset.

Test Plan:
- Header size PT=256, AAD=128 (total 3), key=K1, then blocks A0,P0,P1 -> 2 cycles after the P1 handshake: o_new_instance=1 with o_aad=A0; next cycle o_plain_text=P0, o_pt_instance=1; next P1; then o_aad/o_plain_text/o_pt_instance=0, o_busy=0.
- Header PT=0, AAD=0; then PT=100 bits; then total=DEPTH+1 -> o_err pulses each time, o_hdr_ready stays 1, outputs unchanged.
- PT-only 16 blocks, i_blk_valid toggling 50% -> all 16 issued on 16 consecutive cycles, no gap, o_new_instance only on block 0.
- Second header (key K2) accepted during the final issue cycle of instance 1 -> o_cipher_key stays K1 until block 0 of instance 2 is issued.
- Assert rst_n=0 during ISSUE at block 2 of 5 -> all outputs 0 asynchronously; after release, o_hdr_ready=1 and no residual blocks issued.
- (AES_SEQ_ABORT_EN) i_abort after 2 of 4 blocks loaded -> o_err pulse, IDLE; a fresh 1-block instance then issues correctly.
